// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time and answers after LATENCY cycles
// with extended load data or an error flag, backed by a byte-enabled word RAM.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT_EXT = BASE_EXT + (33'(DEPTH_WORDS) << 2);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        rw;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
  } req_t;

  state_t      state;
  logic [3:0]  cnt;
  req_t        live_req, held_req, acc;
  logic        accept, commit, err;
  logic [32:0] addr_ext;
  logic [IDX_W-1:0] idx;
  logic [1:0]  lane;
  logic [3:0]  be;
  logic [31:0] wword, rd_word, shifted, load_data;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign live_req  = '{addr: req_addr, rw: req_rw, size: req_size, uns: req_unsigned,
                       wdata: req_wdata};

  // With LATENCY 1 the accept edge is also the commit edge, so the live request is used.
  assign commit = (LATENCY == 1) ? accept : ((state == WAIT) && (cnt == 4'd0));
  assign acc    = (LATENCY == 1) ? live_req : held_req;

  assign addr_ext = {1'b0, acc.addr};
  assign idx      = IDX_W'((acc.addr - BASE_ADDR) >> 2);
  assign lane     = acc.addr[1:0];
  assign err      = (acc.size == 2'b11)
                 || ((acc.size == 2'b01) && acc.addr[0])
                 || ((acc.size == 2'b10) && (acc.addr[1:0] != 2'b00))
                 || (addr_ext < BASE_EXT) || (addr_ext >= LIMIT_EXT);

  assign rd_word = mem[idx];
  assign shifted = rd_word >> {lane, 3'b000};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    be        = 4'h0;
    wword     = 32'h0;
    load_data = rd_word;
    case (acc.size)
      2'b00: begin
        be        = 4'b0001 << lane;
        wword     = {4{acc.wdata[7:0]}};
        load_data = acc.uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        be        = 4'b0011 << lane;
        wword     = {2{acc.wdata[15:0]}};
        load_data = acc.uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be    = 4'hF;
        wword = acc.wdata;
      end
    endcase
  end

  // NOTE: the storage array has no reset; clearing a RAM would cost a write port per word.
  always_ff @(posedge clock) begin
    if (commit && acc.rw && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      held_req   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            held_req <= live_req;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              cnt   <= 4'(LATENCY - 2);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (commit) begin
        resp_valid <= 1'b1;
        resp_err   <= err;
        resp_rdata <= (err || acc.rw) ? 32'h0 : load_data;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance and a small LATENCY=1 instance
// share request buses; sel picks which one is driven and observed.
module tb_dmem_responder;
  localparam logic [31:0] BASE   = 32'h0100_0000;
  localparam int          DEPTH1 = 16;
  localparam logic [1:0]  SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, req_valid, req_rw, req_unsigned, resp_ready, sel;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        v0, v1, rdy0, rdy1, rv0, rv1, er0, er1;
  logic [31:0] rd0, rd1;
  logic        obs_ready, obs_valid, obs_err;
  logic [31:0] obs_rdata;

  assign v0        = req_valid && !sel;
  assign v1        = req_valid && sel;
  assign obs_ready = sel ? rdy1 : rdy0;
  assign obs_valid = sel ? rv1 : rv0;
  assign obs_rdata = sel ? rd1 : rd0;
  assign obs_err   = sel ? er1 : er0;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset), .req_valid(v0), .req_ready(rdy0), .req_addr(req_addr),
    .req_rw(req_rw), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_ready(resp_ready), .resp_rdata(rd0), .resp_err(er0));

  dmem_responder #(.DEPTH_WORDS(DEPTH1), .LATENCY(1), .BASE_ADDR(BASE)) dut1 (
    .clock(clock), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_addr(req_addr),
    .req_rw(req_rw), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_ready(resp_ready), .resp_rdata(rd1), .resp_err(er1));

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drives one request and waits for its accept edge; queues the expected response if push.
  task automatic issue(input string tag, input logic rw, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input logic exp_err, input bit push);
    int n;
    @(negedge clock);
    req_valid = 1'b1; req_rw = rw; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!obs_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_accept_wait"}, n, 0);
    if (push) exp_q.push_back('{tag, exp_data, exp_err});
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  // Called #1 after the accept edge: waits for resp_valid, checks latency and the scoreboard.
  task automatic await_resp(input int lat);
    int   n;
    exp_t e;
    n = 1;
    while (!obs_valid && n < 40) begin
      @(posedge clock);
      #1 n++;
    end
    e = exp_q.pop_front();
    check({e.tag, "_latency"}, n, lat);
    check({e.tag, "_rdata"}, obs_rdata, e.data);
    check({e.tag, "_err"}, obs_err, e.err);
  endtask

  task automatic xact(input string tag, input logic rw, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_data, input logic exp_err);
    issue(tag, rw, size, uns, addr, wdata, exp_data, exp_err, 1'b1);
    await_resp(sel ? 1 : 2);
    @(posedge clock);
    #1;
    check({tag, "_drain_valid"}, obs_valid, 0);
    check({tag, "_drain_rdata"}, obs_rdata, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_size = SZ_W;
    req_unsigned = 1'b0; req_addr = BASE; req_wdata = 32'h0; resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_req_ready", obs_ready, 0);
    check("rst_resp_valid", obs_valid, 0);
    check("rst_resp_rdata", obs_rdata, 0);
    check("rst_resp_err", obs_err, 0);
    @(negedge clock) reset = 1'b0;

    xact("sw_seed", 1'b1, SZ_W, 1'b0, BASE + 32'h10, 32'h1122_3344, 32'h0, 1'b0);

    // Store abandoned in WAIT; a request presented during reset must not be taken either.
    issue("sw_abandon", 1'b1, SZ_W, 1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("mid_wait_req_ready", obs_ready, 0);
    check("mid_wait_resp_valid", obs_valid, 0);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = BASE + 32'h10; req_wdata = 32'h0;
    @(posedge clock);
    #1 check("rst_hs_req_ready", obs_ready, 0);
    @(negedge clock);
    reset = 1'b0; req_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1 check("rst_hs_no_resp", obs_valid, 0);
    xact("lw_after_rst", 1'b0, SZ_W, 1'b0, BASE + 32'h10, 32'h0, 32'h1122_3344, 1'b0);

    // Extraction and extension.
    xact("sw_8899", 1'b1, SZ_W, 1'b0, BASE + 32'h20, 32'h8899_AABB, 32'h0, 1'b0);
    xact("lb_23",  1'b0, SZ_B, 1'b0, BASE + 32'h23, 32'h0, 32'hFFFF_FF88, 1'b0);
    xact("lbu_23", 1'b0, SZ_B, 1'b1, BASE + 32'h23, 32'h0, 32'h0000_0088, 1'b0);
    xact("lh_22",  1'b0, SZ_H, 1'b0, BASE + 32'h22, 32'h0, 32'hFFFF_8899, 1'b0);
    xact("lhu_22", 1'b0, SZ_H, 1'b1, BASE + 32'h22, 32'h0, 32'h0000_8899, 1'b0);
    xact("lbu_21", 1'b0, SZ_B, 1'b1, BASE + 32'h21, 32'h0, 32'h0000_00AA, 1'b0);
    xact("lh_20",  1'b0, SZ_H, 1'b0, BASE + 32'h20, 32'h0, 32'hFFFF_AABB, 1'b0);

    // Partial stores; upper wdata bits must be ignored.
    xact("sb_21", 1'b1, SZ_B, 1'b0, BASE + 32'h21, 32'hFFFF_FF55, 32'h0, 1'b0);
    xact("lw_sb", 1'b0, SZ_W, 1'b0, BASE + 32'h20, 32'h0, 32'h8899_55BB, 1'b0);
    xact("sh_20", 1'b1, SZ_H, 1'b0, BASE + 32'h20, 32'hABCD_1234, 32'h0, 1'b0);
    xact("lw_sh", 1'b0, SZ_W, 1'b0, BASE + 32'h20, 32'h0, 32'h8899_1234, 1'b0);

    // Error cases.
    xact("lh_mis",   1'b0, SZ_H,  1'b0, BASE + 32'h1,    32'h0, 32'h0, 1'b1);
    xact("lw_mis",   1'b0, SZ_W,  1'b0, BASE + 32'h2,    32'h0, 32'h0, 1'b1);
    xact("size_11",  1'b0, 2'b11, 1'b0, BASE,            32'h0, 32'h0, 1'b1);
    xact("lw_below", 1'b0, SZ_W,  1'b0, BASE - 32'h4,    32'h0, 32'h0, 1'b1);
    xact("lw_above", 1'b0, SZ_W,  1'b0, BASE + 32'h1000, 32'h0, 32'h0, 1'b1);
    xact("sw_40",    1'b1, SZ_W,  1'b0, BASE + 32'h40,   32'hCAFE_F00D, 32'h0, 1'b0);
    xact("sw_mis",   1'b1, SZ_W,  1'b0, BASE + 32'h42,   32'h0, 32'h0, 1'b1);
    xact("lw_40",    1'b0, SZ_W,  1'b0, BASE + 32'h40,   32'h0, 32'hCAFE_F00D, 1'b0);

    // Back-pressure: response held 5 cycles while a competing request is presented.
    resp_ready = 1'b0;
    issue("lw_bp", 1'b0, SZ_W, 1'b0, BASE + 32'h20, 32'h0, 32'h8899_1234, 1'b0, 1'b1);
    await_resp(2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      req_valid = 1'b1; req_rw = 1'b1; req_size = SZ_W; req_addr = BASE + 32'h40;
      req_wdata = 32'h0BAD_0BAD;
      @(posedge clock);
      #1;
      check("bp_valid", obs_valid, 1);
      check("bp_rdata", obs_rdata, 32'h8899_1234);
      check("bp_req_ready", obs_ready, 0);
    end
    @(negedge clock);
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clock);
    #1;
    check("bp_release_valid", obs_valid, 0);
    check("bp_release_ready", obs_ready, 1);
    xact("lw_40_post_bp", 1'b0, SZ_W, 1'b0, BASE + 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0);

    // Reset while a response is pending drops it immediately.
    resp_ready = 1'b0;
    issue("lw_drop", 1'b0, SZ_W, 1'b0, BASE + 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
    n = 0;
    while (!obs_valid && n < 20) begin
      @(posedge clock);
      #1 n++;
    end
    check("drop_reached_resp", obs_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("drop_resp_valid", obs_valid, 0);
    check("drop_resp_rdata", obs_rdata, 0);
    check("drop_req_ready", obs_ready, 0);
    @(negedge clock);
    reset = 1'b0; resp_ready = 1'b1;

    // LATENCY=1 instance with a 16-word array.
    sel = 1'b1;
    xact("l1_sw_top", 1'b1, SZ_W, 1'b0, BASE + 32'(4 * (DEPTH1 - 1)), 32'hA5A5_5A5A,
         32'h0, 1'b0);
    xact("l1_lw_top", 1'b0, SZ_W, 1'b0, BASE + 32'(4 * (DEPTH1 - 1)), 32'h0,
         32'hA5A5_5A5A, 1'b0);
    xact("l1_lw_beyond", 1'b0, SZ_W, 1'b0, BASE + 32'(4 * DEPTH1), 32'h0, 32'h0, 1'b1);
    xact("l1_lhu_top", 1'b0, SZ_H, 1'b1, BASE + 32'(4 * (DEPTH1 - 1) + 2), 32'h0,
         32'h0000_A5A5, 1'b0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
